retire_trace_buf: RTL and testbench
===================================

Name: retire_trace_buf

Overview:
- Buffers retired-instruction records from the turbo CPU writeback stage and presents them one at a time to a downstream checker or debug reader.
- Each record is the 70-bit retire word:
  - bit 69: rf_en
  - bits 68:64: rf_waddr
  - bits 63:32: rf_wdata
  - bits 31:0: pc
- Decouples a pipeline that retires at most one instruction per cycle from a slower consumer.
- Reports drops and maintains retire/drop statistics.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- FILTER_X0, 1, when 1 only records with rf_en=1 and rf_waddr!=0 are enqueued; when 0 every retired instruction is enqueued.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wb_valid  in  1  one instruction retires this cycle
- wb_pc  in  32  PC of the retiring instruction
- wb_rf_en  in  1  register-file write enable
- wb_rf_waddr  in  5  destination register
- wb_rf_wdata  in  32  write-back data
- out_valid  out  1  head record available
- out_ready  in  1  consumer accepts head record
- out_record  out  70  head record {rf_en, waddr, wdata, pc}
- overflow  out  1  sticky: at least one record dropped
- retire_cnt  out  32  count of wb_valid cycles; wraps
- drop_cnt  out  16  count of dropped records; saturates at 0xFFFF
- retire_stall  out  1  backpressure to the CPU; only meaningful under RETIRE_STALL_EN

Behaviour:
- Reset (async on rst=1, effective immediately): pointers=0, out_valid=0, overflow=0, retire_cnt=0, drop_cnt=0, retire_stall=0.
  - FIFO contents are don't-care.
  - out_record is driven to 0 while empty.
- Reset mid-operation discards all queued records.
- Candidate push: wb_valid && (FILTER_X0==0 || (wb_rf_en && wb_rf_waddr!=0)).
- Pop: out_valid && out_ready.
- Show-ahead FIFO:
  - out_valid = !empty.
  - out_record = head entry, combinational from the storage read.
  - A pushed record becomes visible on out_valid one cycle after the push edge.
  - Latency from push to out_valid is 1 cycle.
- Pointers are log2(DEPTH)+1 bits.
  - full when the addresses are equal and the MSBs differ.
  - empty when the pointers are equal.
  - Pointers wrap naturally modulo 2*DEPTH.
- Push while full and no pop in the same cycle: record dropped, overflow<=1, drop_cnt increments (saturating). FIFO is unchanged.
- Push and pop in the same cycle while full: pop frees the slot and the push is accepted. Occupancy is unchanged; no drop.
- Push and pop in the same cycle while empty: the push is accepted and the pop is ignored, because out_valid=0.
- Pop with out_ready=1 while empty: no effect.
- retire_cnt increments on every wb_valid=1, independent of filtering and drops.
- No state machine beyond the FIFO occupancy. States are EMPTY, PARTIAL, FULL, derived from the pointers.

Optional Feature:
- Macro: RETIRE_STALL_EN.
- Defined:
  - retire_stall = full && !(out_valid && out_ready), combinational.
  - The CPU must hold wb_* stable and not retire while retire_stall=1. A wb_valid asserted while stalled is ignored (not counted, not dropped).
  - overflow and drop_cnt remain 0.
- Undefined: retire_stall is tied to 0 and drop behaviour applies as above.

Decomposition:
- Shared package/header holds:
  - RETIRE_REC_W=70
  - field offsets: PC_LSB=0, WDATA_LSB=32, WADDR_LSB=64, RFEN_BIT=69
- The record packer stays in retire_trace_buf.
- One sub-module: retire_fifo (parameterised width/depth, show-ahead sync FIFO with full/empty), instantiated once.

Test Plan:
- Reset then a single push (wb_pc=0x0000_0040, rf_en=1, waddr=5, wdata=0xDEADBEEF):
  - out_valid=1 on the next cycle.
  - out_record=70'h2_5_DEADBEEF_00000040 (field-concatenated).
  - pop returns out_valid=0.
- FILTER_X0=1, push with waddr=0 and a push with rf_en=0:
  - nothing enqueued.
  - retire_cnt=2, out_valid stays 0.
- DEPTH=16, out_ready=0, 20 consecutive valid pushes:
  - 16 stored, drop_cnt=4, overflow=1.
  - draining yields the first 16 PCs in order.
- FIFO full, same-cycle push and pop:
  - occupancy stays 16, drop_cnt unchanged.
  - the new record appears at position 16 of the drain.
- Assert rst mid-stream with 7 entries queued:
  - out_valid=0 immediately.
  - all counters 0.
  - the next push is the first record read out.
- With RETIRE_STALL_EN, fill to 16 with out_ready=0:
  - retire_stall=1.
  - raising out_ready drops retire_stall in the same cycle.
  - overflow remains 0.

Source files
------------

// File: rtl/retire_trace_buf_pkg.sv
// ---------------------------------------------------------------------------
// retire_trace_buf_pkg
//   Shared definitions for the retire trace buffer:
//     - RETIRE_REC_W and the field offsets of the 70-bit retire word
//       {rf_en, rf_waddr, rf_wdata, pc}
//     - fifo_state_e: occupancy state (EMPTY / PARTIAL / FULL) that the FIFO
//       derives from its pointers and exports for observation
//     - pack_record(): builds a retire word from its fields
// ---------------------------------------------------------------------------
package retire_trace_buf_pkg;

   localparam int RETIRE_REC_W = 70;
   localparam int PC_LSB       = 0;
   localparam int WDATA_LSB    = 32;
   localparam int WADDR_LSB    = 64;
   localparam int RFEN_BIT     = 69;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } fifo_state_e;

   function automatic logic [RETIRE_REC_W-1:0] pack_record(
      input logic        rf_en,
      input logic [4:0]  rf_waddr,
      input logic [31:0] rf_wdata,
      input logic [31:0] pc
   );
      logic [RETIRE_REC_W-1:0] rec;
      rec                     = '0;
      rec[RFEN_BIT]           = rf_en;
      rec[WADDR_LSB +: 5]     = rf_waddr;
      rec[WDATA_LSB +: 32]    = rf_wdata;
      rec[PC_LSB +: 32]       = pc;
      return rec;
   endfunction

endpackage

// File: rtl/retire_trace_buf_fifo.sv
// ---------------------------------------------------------------------------
// retire_fifo
//   Show-ahead synchronous FIFO. The head entry is presented combinationally
//   on rdata (forced to 0 while empty); a written entry is visible the cycle
//   after the write edge.
//
//   Ports:
//     clk, rst   clock, asynchronous active-high reset (clears pointers)
//     push       write request; accepted when not full, or when full and a
//                pop happens in the same cycle
//     wdata      data written on an accepted push
//     pop        read request; ignored while empty
//     rdata      head entry (0 while empty)
//     state      occupancy state EMPTY / PARTIAL / FULL
//
//   Pointers carry one extra wrap bit: equal pointers mean empty, equal
//   addresses with differing wrap bits mean full.
// ---------------------------------------------------------------------------
module retire_fifo
   import retire_trace_buf_pkg::*;
#(
   parameter int WIDTH = 70,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output fifo_state_e      state
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full;
   logic             empty;
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                  (wr_ptr[AW] != rd_ptr[AW]);

   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the head slot, so a push into a full
   // FIFO is still accepted and occupancy stays unchanged.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage is not reset; its contents are meaningless while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_comb begin
      state = ST_PARTIAL;
      if (empty)     state = ST_EMPTY;
      else if (full) state = ST_FULL;
   end

endmodule

// File: rtl/retire_trace_buf.sv
// ---------------------------------------------------------------------------
// retire_trace_buf
//   Buffers retired-instruction records from the CPU writeback stage and
//   presents them one at a time to a slower consumer, with drop reporting
//   and retire/drop statistics.
//
//   Build option: define RETIRE_STALL_EN to backpressure the CPU through
//   retire_stall instead of dropping records when the buffer is full.
//
//   Parameters:
//     DEPTH      FIFO entries (power of two, >= 2)
//     FILTER_X0  1: enqueue only records with rf_en=1 and rf_waddr!=0
//                0: enqueue every retired instruction
//
//   Ports:
//     clk, rst       clock, asynchronous active-high reset
//     wb_valid       one instruction retires this cycle
//     wb_pc          PC of the retiring instruction
//     wb_rf_en       register-file write enable
//     wb_rf_waddr    destination register
//     wb_rf_wdata    write-back data
//     out_valid      head record available
//     out_ready      consumer accepts head record
//     out_record     head record {rf_en, waddr, wdata, pc}, 0 while empty
//     overflow       sticky: at least one record dropped
//     retire_cnt     count of accepted wb_valid cycles, wraps
//     drop_cnt       dropped records, saturates at 0xFFFF
//     retire_stall   backpressure to the CPU (0 unless RETIRE_STALL_EN)
//
//   Output handshake: a record transfers on every rising clk edge where
//   out_valid && out_ready. out_valid does not depend on out_ready; once
//   asserted, the head record stays put until it is taken or rst clears it.
// ---------------------------------------------------------------------------
module retire_trace_buf
   import retire_trace_buf_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int FILTER_X0 = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wb_valid,
   input  logic [31:0]             wb_pc,
   input  logic                    wb_rf_en,
   input  logic [4:0]              wb_rf_waddr,
   input  logic [31:0]             wb_rf_wdata,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [RETIRE_REC_W-1:0] out_record,
   output logic                    overflow,
   output logic [31:0]             retire_cnt,
   output logic [15:0]             drop_cnt,
   output logic                    retire_stall
);

   fifo_state_e             fifo_state;
   logic                    full;
   logic                    pop;
   logic                    retire;
   logic                    candidate;
   logic                    drop;
   logic [RETIRE_REC_W-1:0] wb_record;

   assign full      = (fifo_state == ST_FULL);
   assign out_valid = (fifo_state != ST_EMPTY);
   assign pop       = out_valid && out_ready;

   assign wb_record = pack_record(wb_rf_en, wb_rf_waddr, wb_rf_wdata, wb_pc);

`ifdef RETIRE_STALL_EN
   // Full with no pop this cycle: hold the CPU. A retire offered while
   // stalled is ignored entirely, so nothing can ever be dropped.
   assign retire_stall = full && !pop;
   assign retire       = wb_valid && !retire_stall;
   assign drop         = 1'b0;
`else
   assign retire_stall = 1'b0;
   assign retire       = wb_valid;
`endif

   // Writes to x0 and non-writing instructions carry no architectural state
   // change, so the filter keeps them out of the buffer.
   assign candidate = retire &&
                      ((FILTER_X0 == 0) || (wb_rf_en && (wb_rf_waddr != 5'd0)));

`ifndef RETIRE_STALL_EN
   assign drop = candidate && full && !pop;
`endif

   retire_fifo #(
      .WIDTH (RETIRE_REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (candidate),
      .wdata (wb_record),
      .pop   (pop),
      .rdata (out_record),
      .state (fifo_state)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow   <= 1'b0;
         retire_cnt <= '0;
         drop_cnt   <= '0;
      end else begin
         if (retire) retire_cnt <= retire_cnt + 32'd1;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_retire_trace_buf.sv
// ---------------------------------------------------------------------------
// tb_retire_trace_buf
//   Self-checking bench for retire_trace_buf (DEPTH=16, FILTER_X0=1).
//   Inputs change on the falling edge; outputs are compared on the falling
//   edge against a queue-based reference of the buffer's behaviour.
// ---------------------------------------------------------------------------
module tb_retire_trace_buf;

   localparam int DEPTH = 16;
   localparam int W     = 70;
`ifdef RETIRE_STALL_EN
   localparam bit STALL = 1'b1;
`else
   localparam bit STALL = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          wb_valid    = 1'b0;
   logic [31:0]   wb_pc       = '0;
   logic          wb_rf_en    = 1'b0;
   logic [4:0]    wb_rf_waddr = '0;
   logic [31:0]   wb_rf_wdata = '0;
   logic          out_ready   = 1'b0;
   logic          out_valid;
   logic [W-1:0]  out_record;
   logic          overflow;
   logic [31:0]   retire_cnt;
   logic [15:0]   drop_cnt;
   logic          retire_stall;

   retire_trace_buf #(.DEPTH(DEPTH), .FILTER_X0(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .wb_valid     (wb_valid),
      .wb_pc        (wb_pc),
      .wb_rf_en     (wb_rf_en),
      .wb_rf_waddr  (wb_rf_waddr),
      .wb_rf_wdata  (wb_rf_wdata),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_record   (out_record),
      .overflow     (overflow),
      .retire_cnt   (retire_cnt),
      .drop_cnt     (drop_cnt),
      .retire_stall (retire_stall)
   );

   // ---------------- reference model / scoreboard ----------------
   logic [W-1:0] exp_q[$];
   logic         m_overflow;
   logic [31:0]  m_retire;
   logic [15:0]  m_drop;
   int           errors = 0;
   int           checks = 0;

   function automatic logic [W-1:0] rec_of(logic en, logic [4:0] a,
                                           logic [31:0] d, logic [31:0] pc);
      return {en, a, d, pc};
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_overflow = 1'b0;
      m_retire   = '0;
      m_drop     = '0;
   endtask

   // ---------------- driver ----------------
   // Called at a falling edge: applies one cycle of inputs, advances the
   // reference across the next rising edge, returns at the next falling edge.
   task automatic drive_cycle(input logic v, input logic [31:0] pc,
                              input logic en, input logic [4:0] a,
                              input logic [31:0] d, input logic rdy);
      bit popped, stalled, cand;
      wb_valid    = v;
      wb_pc       = pc;
      wb_rf_en    = en;
      wb_rf_waddr = a;
      wb_rf_wdata = d;
      out_ready   = rdy;
      popped  = (exp_q.size() > 0) && rdy;
      stalled = STALL && (exp_q.size() == DEPTH) && !popped;
      cand    = 1'b0;
      if (v && !stalled) begin
         m_retire = m_retire + 1;
         cand = en && (a != 5'd0);
      end
      if (popped) void'(exp_q.pop_front());
      if (cand) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(rec_of(en, a, d, pc));
         else begin
            m_overflow = 1'b1;
            if (m_drop != 16'hFFFF) m_drop = m_drop + 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic rdy);
      drive_cycle(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, rdy);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      wb_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_record !== '0 || overflow !== 1'b0 ||
          retire_cnt !== 32'd0 || drop_cnt !== 16'd0 || retire_stall !== 1'b0) begin
         errors++;
         $display("FAIL reset: valid=%b rec=%h ovf=%b ret=%0d drop=%0d stall=%b expected all 0",
                  out_valid, out_record, overflow, retire_cnt, drop_cnt, retire_stall);
      end
      apply_reset();
   endtask

   task automatic test_single();
      logic [W-1:0] exp_rec;
      exp_rec = 70'h25_DEADBEEF_00000040;
      drive_cycle(1'b1, 32'h0000_0040, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
      wb_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_record !== exp_rec) begin
         errors++;
         $display("FAIL single_push: valid=%b rec=%h expected valid=1 rec=%h",
                  out_valid, out_record, exp_rec);
      end
      idle(1'b1);
      checks++;
      if (out_valid !== 1'b0 || out_record !== '0) begin
         errors++;
         $display("FAIL single_pop: valid=%b rec=%h expected 0/0", out_valid, out_record);
      end
   endtask

   task automatic test_filter();
      apply_reset();
      drive_cycle(1'b1, 32'h100, 1'b1, 5'd0, 32'h1111_1111, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL filter_x0: valid=%b expected 0", out_valid);
      end
      drive_cycle(1'b1, 32'h104, 1'b0, 5'd7, 32'h2222_2222, 1'b0);
      idle(1'b0);
      checks++;
      if (out_valid !== 1'b0 || retire_cnt !== 32'd2 || retire_cnt !== m_retire) begin
         errors++;
         $display("FAIL filter_noen: valid=%b ret=%0d expected valid=0 ret=2",
                  out_valid, retire_cnt);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] exp_drop;
      logic        exp_ovf;
      exp_drop = STALL ? 16'd0 : 16'd4;
      exp_ovf  = !STALL;
      apply_reset();
      for (int i = 0; i < 20; i++)
         drive_cycle(1'b1, 32'h1000 + 4 * i, 1'b1, 5'd1 + 5'(i % 31), 32'(i), 1'b0);
      wb_valid = 1'b0;
      checks++;
      if (drop_cnt !== exp_drop || overflow !== exp_ovf || exp_q.size() != DEPTH) begin
         errors++;
         $display("FAIL overflow_counts: drop=%0d ovf=%b expected drop=%0d ovf=%b",
                  drop_cnt, overflow, exp_drop, exp_ovf);
      end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_record[31:0] !== 32'h1000 + 4 * i ||
             out_record !== exp_q[0]) begin
            errors++;
            $display("FAIL overflow_drain[%0d]: valid=%b rec=%h expected pc=%h rec=%h",
                     i, out_valid, out_record, 32'h1000 + 4 * i, exp_q[0]);
         end
         idle(1'b1);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL overflow_empty: valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_full_push_pop();
      logic [15:0] drop_before;
      logic [W-1:0] new_rec;
      for (int i = 0; i < DEPTH; i++)
         drive_cycle(1'b1, 32'h2000 + 4 * i, 1'b1, 5'd3, 32'hA0 + i, 1'b0);
      drop_before = drop_cnt;
      new_rec = rec_of(1'b1, 5'd9, 32'hCAFE_F00D, 32'h2FFC);
      drive_cycle(1'b1, 32'h2FFC, 1'b1, 5'd9, 32'hCAFE_F00D, 1'b1);
      wb_valid = 1'b0;
      checks++;
      if (drop_cnt !== drop_before || drop_cnt !== m_drop || exp_q.size() != DEPTH) begin
         errors++;
         $display("FAIL full_pushpop_drop: drop=%0d expected %0d", drop_cnt, drop_before);
      end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_record !== exp_q[0]) begin
            errors++;
            $display("FAIL full_pushpop_drain[%0d]: valid=%b rec=%h expected %h",
                     i, out_valid, out_record, exp_q[0]);
         end
         if (i == DEPTH - 1) begin
            checks++;
            if (out_record !== new_rec) begin
               errors++;
               $display("FAIL full_pushpop_last: rec=%h expected %h", out_record, new_rec);
            end
         end
         idle(1'b1);
      end
   endtask

   task automatic test_mid_reset();
      logic [W-1:0] first_rec;
      apply_reset();
      for (int i = 0; i < 7; i++)
         drive_cycle(1'b1, 32'h3000 + 4 * i, 1'b1, 5'd4, 32'(i), 1'b0);
      wb_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || retire_cnt !== 32'd7) begin
         errors++;
         $display("FAIL midrst_pre: valid=%b ret=%0d expected 1/7", out_valid, retire_cnt);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || retire_cnt !== 32'd0 || drop_cnt !== 16'd0 ||
          overflow !== 1'b0) begin
         errors++;
         $display("FAIL midrst_async: valid=%b ret=%0d drop=%0d ovf=%b expected all 0",
                  out_valid, retire_cnt, drop_cnt, overflow);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      first_rec = rec_of(1'b1, 5'd12, 32'h5555_AAAA, 32'h4000);
      drive_cycle(1'b1, 32'h4000, 1'b1, 5'd12, 32'h5555_AAAA, 1'b0);
      wb_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_record !== first_rec) begin
         errors++;
         $display("FAIL midrst_first: valid=%b rec=%h expected %h", out_valid, out_record, first_rec);
      end
      idle(1'b1);
   endtask

   task automatic test_random();
      logic        v, en, rdy;
      logic [4:0]  a;
      logic [31:0] pc;
      apply_reset();
      pc = 32'h8000_0000;
      for (int i = 0; i < 400; i++) begin
         v   = ($urandom_range(0, 9) < 8);
         en  = ($urandom_range(0, 3) != 0);
         a   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         rdy = ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 3 : 8));
         drive_cycle(v, pc, en, a, $urandom, rdy);
         if (v) pc = pc + 4;
         checks++;
         if (out_valid !== (exp_q.size() > 0) ||
             out_record !== (exp_q.size() > 0 ? exp_q[0] : '0)) begin
            errors++;
            $display("FAIL random_head[%0d]: valid=%b rec=%h expected valid=%b",
                     i, out_valid, out_record, exp_q.size() > 0);
         end
      end
      checks++;
      if (retire_cnt !== m_retire || drop_cnt !== m_drop || overflow !== m_overflow) begin
         errors++;
         $display("FAIL random_stats: ret=%0d drop=%0d ovf=%b expected ret=%0d drop=%0d ovf=%b",
                  retire_cnt, drop_cnt, overflow, m_retire, m_drop, m_overflow);
      end
      wb_valid = 1'b0;
   endtask

`ifdef RETIRE_STALL_EN
   task automatic test_stall();
      apply_reset();
      for (int i = 0; i < DEPTH; i++)
         drive_cycle(1'b1, 32'h6000 + 4 * i, 1'b1, 5'd2, 32'(i), 1'b0);
      wb_valid = 1'b0;
      #1;
      checks++;
      if (retire_stall !== 1'b1) begin
         errors++;
         $display("FAIL stall_full: stall=%b expected 1", retire_stall);
      end
      drive_cycle(1'b1, 32'h6FFC, 1'b1, 5'd2, 32'h77, 1'b0);
      checks++;
      if (retire_cnt !== 32'd16 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL stall_ignore: ret=%0d drop=%0d ovf=%b expected 16/0/0",
                  retire_cnt, drop_cnt, overflow);
      end
      wb_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++;
      if (retire_stall !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: stall=%b expected 0", retire_stall);
      end
      for (int i = 0; i < DEPTH; i++) idle(1'b1);
      checks++;
      if (out_valid !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL stall_drain: valid=%b ovf=%b expected 0/0", out_valid, overflow);
      end
   endtask
`endif

   // ---------------- sequence / report ----------------
   initial begin
      model_reset();
      test_reset();
      test_single();
      test_filter();
      test_overflow();
      test_full_push_pop();
      test_mid_reset();
      test_random();
`ifdef RETIRE_STALL_EN
      test_stall();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
